// File: rtl/operand_forward_unit.sv
// ID->EX operand forwarding, operand latch and stall control for the hazard-control interface.
// States: RUN | normal issue, operands load every cycle
//         STALL | load-use hold in progress, ID/EX carries a bubble
module operand_forward_unit #(
  parameter int XLEN      = 32,
  parameter int MAX_STALL = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            fwd_ex1,
  input  logic            fwd_ex2,
  input  logic            fwd_mem1,
  input  logic            fwd_mem2,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] ex_result,
  input  logic            mem_is_load,
  input  logic [XLEN-1:0] mem_alu,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [XLEN-1:0] op_a,
  output logic [XLEN-1:0] op_b,
  output logic            op_valid,
  output logic            pc_hold,
  output logic            ifid_hold,
  output logic [1:0]      fwd_sel_a,
  output logic [1:0]      fwd_sel_b,
  output logic            hazard_err
);

  localparam int            CW      = $clog2(MAX_STALL + 2);
  localparam logic [CW-1:0] CNT_SAT = CW'(MAX_STALL + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_STALL);

  typedef enum logic {S_RUN, S_STALL} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_op_a;
  logic [XLEN-1:0] r_op_b;
  logic            r_op_valid;
  logic [1:0]      r_sel_a;
  logic [1:0]      r_sel_b;
  logic            r_hazard_err;

  logic [XLEN-1:0] w_wb_val;
  logic [XLEN-1:0] w_src_a;
  logic [XLEN-1:0] w_src_b;
  logic [1:0]      w_sel_a;
  logic [1:0]      w_sel_b;
  logic [CW-1:0]   w_cnt_nxt;

  assign w_wb_val = mem_is_load ? mem_rdata : mem_alu;

  // EX is the more recent producer, so it beats MEM when both flags are set.
  always_comb begin
    w_src_a = rs1_data;
    w_sel_a = 2'd0;
    if (fwd_ex1) begin
      w_src_a = ex_result;
      w_sel_a = 2'd1;
    end else if (fwd_mem1) begin
      w_src_a = w_wb_val;
      w_sel_a = 2'd2;
    end
  end

  always_comb begin
    w_src_b = rs2_data;
    w_sel_b = 2'd0;
    if (fwd_ex2) begin
      w_src_b = ex_result;
      w_sel_b = 2'd1;
    end else if (fwd_mem2) begin
      w_src_b = w_wb_val;
      w_sel_b = 2'd2;
    end
  end

  always_comb begin
    w_cnt_nxt = CW'(1);
    if (r_state == S_STALL) begin
      w_cnt_nxt = (r_cnt == CNT_SAT) ? r_cnt : r_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_RUN;
      r_cnt        <= '0;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_op_valid   <= 1'b0;
      r_sel_a      <= 2'd0;
      r_sel_b      <= 2'd0;
      r_hazard_err <= 1'b0;
    end else if (stall) begin
      r_state    <= S_STALL;
      r_cnt      <= w_cnt_nxt;
      r_op_valid <= 1'b0;
      if (w_cnt_nxt > CNT_MAX) r_hazard_err <= 1'b1;
    end else begin
      r_state    <= S_RUN;
      r_cnt      <= '0;
      r_op_a     <= w_src_a;
      r_op_b     <= w_src_b;
      r_sel_a    <= w_sel_a;
      r_sel_b    <= w_sel_b;
      r_op_valid <= 1'b1;
    end
  end

  // Holds follow stall with no latency but must read 0 while reset is asserted.
  assign pc_hold    = stall & rst;
  assign ifid_hold  = stall & rst;
  assign op_a       = r_op_a;
  assign op_b       = r_op_b;
  assign op_valid   = r_op_valid;
  assign fwd_sel_a  = r_sel_a;
  assign fwd_sel_b  = r_sel_b;
  assign hazard_err = r_hazard_err;

endmodule

// File: tb/tb_operand_forward_unit.sv
// Directed self-checking bench for operand_forward_unit (XLEN=32, MAX_STALL=1).
module tb_operand_forward_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, fwd_ex1, fwd_ex2, fwd_mem1, fwd_mem2, mem_is_load;
  logic [31:0] rs1_data, rs2_data, ex_result, mem_alu, mem_rdata;
  logic [31:0] op_a, op_b;
  logic        op_valid, pc_hold, ifid_hold, hazard_err;
  logic [1:0]  fwd_sel_a, fwd_sel_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  operand_forward_unit #(.XLEN(32), .MAX_STALL(1)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .fwd_ex1(fwd_ex1), .fwd_ex2(fwd_ex2), .fwd_mem1(fwd_mem1), .fwd_mem2(fwd_mem2),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .ex_result(ex_result),
    .mem_is_load(mem_is_load), .mem_alu(mem_alu), .mem_rdata(mem_rdata),
    .op_a(op_a), .op_b(op_b), .op_valid(op_valid), .pc_hold(pc_hold),
    .ifid_hold(ifid_hold), .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
    .hazard_err(hazard_err)
  );

  task automatic clear_inputs();
    stall = 0; fwd_ex1 = 0; fwd_ex2 = 0; fwd_mem1 = 0; fwd_mem2 = 0; mem_is_load = 0;
    rs1_data = 0; rs2_data = 0; ex_result = 0; mem_alu = 0; mem_rdata = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    stall = 1;
    rst = 0;
    #12;
    n_tests++; if (op_a !== 32'h0)    begin n_fail++; $display("FAIL reset_op_a got %h exp 0", op_a); end
    n_tests++; if (op_b !== 32'h0)    begin n_fail++; $display("FAIL reset_op_b got %h exp 0", op_b); end
    n_tests++; if (op_valid !== 1'b0) begin n_fail++; $display("FAIL reset_op_valid got %b exp 0", op_valid); end
    n_tests++; if (fwd_sel_a !== 2'd0 || fwd_sel_b !== 2'd0)
      begin n_fail++; $display("FAIL reset_fwd_sel got %0d/%0d exp 0/0", fwd_sel_a, fwd_sel_b); end
    n_tests++; if (pc_hold !== 1'b0 || ifid_hold !== 1'b0)
      begin n_fail++; $display("FAIL reset_holds got %b/%b exp 0/0", pc_hold, ifid_hold); end
    n_tests++; if (hazard_err !== 1'b0) begin n_fail++; $display("FAIL reset_hazard_err got %b exp 0", hazard_err); end
    @(negedge clk);
    stall = 0;
    rst = 1;
    step();
  endtask

  task automatic test_no_hazard();
    clear_inputs();
    rs1_data = 32'h11; rs2_data = 32'h22;
    step();
    n_tests++; if (op_a !== 32'h11) begin n_fail++; $display("FAIL nohaz_op_a got %h exp 11", op_a); end
    n_tests++; if (op_b !== 32'h22) begin n_fail++; $display("FAIL nohaz_op_b got %h exp 22", op_b); end
    n_tests++; if (fwd_sel_a !== 2'd0 || fwd_sel_b !== 2'd0)
      begin n_fail++; $display("FAIL nohaz_fwd_sel got %0d/%0d exp 0/0", fwd_sel_a, fwd_sel_b); end
    n_tests++; if (op_valid !== 1'b1) begin n_fail++; $display("FAIL nohaz_op_valid got %b exp 1", op_valid); end
    n_tests++; if (pc_hold !== 1'b0 || ifid_hold !== 1'b0)
      begin n_fail++; $display("FAIL nohaz_holds got %b/%b exp 0/0", pc_hold, ifid_hold); end
  endtask

  task automatic test_ex_forward();
    clear_inputs();
    rs1_data = 32'h11; rs2_data = 32'h22; ex_result = 32'hDEAD;
    fwd_ex1 = 1; fwd_mem1 = 1; mem_alu = 32'hBEEF; mem_is_load = 0;
    fwd_ex2 = 1;
    step();
    n_tests++; if (op_a !== 32'hDEAD) begin n_fail++; $display("FAIL ex_prio_op_a got %h exp dead", op_a); end
    n_tests++; if (fwd_sel_a !== 2'd1) begin n_fail++; $display("FAIL ex_prio_sel_a got %0d exp 1", fwd_sel_a); end
    n_tests++; if (op_b !== 32'hDEAD || fwd_sel_b !== 2'd1)
      begin n_fail++; $display("FAIL ex_op_b got %h/%0d exp dead/1", op_b, fwd_sel_b); end
  endtask

  task automatic test_load_use();
    clear_inputs();
    stall = 1; fwd_ex1 = 1; ex_result = 32'h7777; rs2_data = 32'h3333;
    #1;
    n_tests++; if (pc_hold !== 1'b1 || ifid_hold !== 1'b1)
      begin n_fail++; $display("FAIL lu_holds got %b/%b exp 1/1", pc_hold, ifid_hold); end
    step();
    n_tests++; if (op_valid !== 1'b0) begin n_fail++; $display("FAIL lu_bubble got %b exp 0", op_valid); end
    n_tests++; if (op_a !== 32'hDEAD || fwd_sel_a !== 2'd1)
      begin n_fail++; $display("FAIL lu_hold_op_a got %h/%0d exp dead/1", op_a, fwd_sel_a); end
    clear_inputs();
    rs1_data = 32'h44; rs2_data = 32'h3333;
    fwd_mem2 = 1; mem_is_load = 1; mem_rdata = 32'h1234; mem_alu = 32'h5678;
    #1;
    n_tests++; if (pc_hold !== 1'b0) begin n_fail++; $display("FAIL lu_release_hold got %b exp 0", pc_hold); end
    step();
    n_tests++; if (op_b !== 32'h1234 || fwd_sel_b !== 2'd2)
      begin n_fail++; $display("FAIL lu_op_b got %h/%0d exp 1234/2", op_b, fwd_sel_b); end
    n_tests++; if (op_valid !== 1'b1 || op_a !== 32'h44)
      begin n_fail++; $display("FAIL lu_replay got valid %b op_a %h exp 1/44", op_valid, op_a); end
    n_tests++; if (hazard_err !== 1'b0) begin n_fail++; $display("FAIL lu_no_err got %b exp 0", hazard_err); end
  endtask

  task automatic test_mem_alu();
    clear_inputs();
    fwd_mem1 = 1; mem_is_load = 0; mem_alu = 32'h55; mem_rdata = 32'h99; rs1_data = 32'h1;
    step();
    n_tests++; if (op_a !== 32'h55 || fwd_sel_a !== 2'd2)
      begin n_fail++; $display("FAIL mem_alu_op_a got %h/%0d exp 55/2", op_a, fwd_sel_a); end
  endtask

  task automatic test_runaway();
    clear_inputs();
    stall = 1;
    step();
    n_tests++; if (hazard_err !== 1'b0) begin n_fail++; $display("FAIL run_stall1 got %b exp 0", hazard_err); end
    step();
    n_tests++; if (hazard_err !== 1'b1) begin n_fail++; $display("FAIL run_stall2 got %b exp 1", hazard_err); end
    step();
    n_tests++; if (hazard_err !== 1'b1) begin n_fail++; $display("FAIL run_stall3 got %b exp 1", hazard_err); end
    stall = 0; rs1_data = 32'h77;
    step();
    n_tests++; if (hazard_err !== 1'b1 || op_valid !== 1'b1 || op_a !== 32'h77)
      begin n_fail++; $display("FAIL run_sticky got err %b valid %b op_a %h exp 1/1/77", hazard_err, op_valid, op_a); end
  endtask

  task automatic test_reset_mid_stall();
    clear_inputs();
    stall = 1;
    step();
    rst = 0;
    #1;
    n_tests++; if (pc_hold !== 1'b0 || ifid_hold !== 1'b0)
      begin n_fail++; $display("FAIL mid_rst_holds got %b/%b exp 0/0", pc_hold, ifid_hold); end
    n_tests++; if (op_valid !== 1'b0 || hazard_err !== 1'b0 || op_a !== 32'h0)
      begin n_fail++; $display("FAIL mid_rst_state got valid %b err %b op_a %h exp 0/0/0", op_valid, hazard_err, op_a); end
    #1;
    stall = 0; rs1_data = 32'hA5; rs2_data = 32'h5A;
    rst = 1;
    step();
    n_tests++; if (op_valid !== 1'b1 || op_a !== 32'hA5 || op_b !== 32'h5A)
      begin n_fail++; $display("FAIL mid_rst_reload got valid %b op_a %h op_b %h exp 1/a5/5a", op_valid, op_a, op_b); end
  endtask

  initial begin
    clear_inputs();
    rst = 0;
    test_reset();
    test_no_hazard();
    test_ex_forward();
    test_load_use();
    test_mem_alu();
    test_runaway();
    test_reset_mid_stall();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
